// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = XLEN / 8;

    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [NB-1:0]         bus_be_o;
    logic [XLEN-1:0]       bus_wdata_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [XLEN-1:0]       bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with req/gnt/rvalid bus and load extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and flag misalign_o.
module mem_access_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  busy_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalign_o,
`endif
    mem_access_unit_if.master     bus
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [ADDR_WIDTH-1:LB]   r_addr;
    logic [LB-1:0]            r_off;
    logic [1:0]               r_size;
    logic                     r_uns;
    logic                     r_we;
    logic [NB-1:0]            r_be;
    logic [XLEN-1:0]          r_wdata;
    logic                     r_flushed;
    logic [XLEN-1:0]          r_rdata;

    logic                     w_accept;
    logic                     w_memop;
    logic                     w_mis;
    logic [1:0]               w_size;
    logic [2:0]               w_amask;
    logic [7:0]               w_mask;
    logic [LB-1:0]            w_off;
    logic [NB-1:0]            w_be;
    logic [XLEN-1:0]          w_wdata;
    logic [XLEN-1:0]          w_sh;
    logic [XLEN-1:0]          w_ld;

    assign w_memop = mem_read_i | mem_write_i;
    // A doubleword on a 32-bit bus degrades to a word access.
    assign w_size  = (XLEN == 32 && funct3_i[1:0] == 2'd3) ? 2'd2 : funct3_i[1:0];

    always_comb begin
        w_amask = 3'd0;
        w_mask  = 8'h00;
        unique case (w_size)
            2'd0: begin w_amask = 3'd0; w_mask = 8'h01; end
            2'd1: begin w_amask = 3'd1; w_mask = 8'h03; end
            2'd2: begin w_amask = 3'd3; w_mask = 8'h0F; end
            2'd3: begin w_amask = 3'd7; w_mask = 8'hFF; end
        endcase
    end

    assign w_off = addr_i[LB-1:0] & ~w_amask[LB-1:0];
    assign w_be  = w_mask[NB-1:0] << w_off;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = w_memop &
                   ((|(addr_i[LB-1:0] & w_amask[LB-1:0])) |
                    (XLEN == 32 && funct3_i[1:0] == 2'd3));
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_wdata = wdata_i;
        unique case (w_size)
            2'd0: w_wdata = {NB{wdata_i[7:0]}};
            2'd1: w_wdata = {(NB/2){wdata_i[15:0]}};
            2'd2: w_wdata = {(NB/4){wdata_i[31:0]}};
            2'd3: w_wdata = wdata_i;
        endcase
    end

    assign w_sh = bus.bus_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ld = w_sh;
        unique case (r_size)
            2'd0: w_ld = r_uns ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]));
            2'd1: w_ld = r_uns ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
            2'd2: w_ld = r_uns ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));
            2'd3: w_ld = w_sh;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        bus.bus_req_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !flush_i) begin
                    w_accept = 1'b1;
                    w_next   = (w_memop && !w_mis) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                bus.bus_req_o = 1'b1;
                if (bus.bus_gnt_i) begin
                    if (r_we) w_next = flush_i ? S_IDLE : S_DONE;
                    else      w_next = S_WAIT;
                end else if (flush_i) begin
                    w_next = S_IDLE;
                end
            end
            // The read response is always drained, even after a flush.
            S_WAIT: begin
                if (bus.bus_rvalid_i)
                    w_next = (r_flushed || flush_i) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                rsp_valid_o = !flush_i;
                w_next      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_off     <= '0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_flushed <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr_i[ADDR_WIDTH-1:LB];
                r_off   <= w_off;
                r_size  <= w_size;
                r_uns   <= funct3_i[2];
                r_we    <= mem_write_i;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                if (!w_memop || w_mis) r_rdata <= '0;
            end
            if (r_state == S_REQ && bus.bus_gnt_i) begin
                if (r_we && !flush_i)  r_rdata   <= '0;
                if (!r_we && flush_i)  r_flushed <= 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (flush_i) r_flushed <= 1'b1;
                if (bus.bus_rvalid_i) begin
                    r_flushed <= 1'b0;
                    if (!r_flushed && !flush_i) r_rdata <= w_ld;
                end
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_mis <= 1'b0;
        else if (w_accept) r_mis <= w_mis;
    end

    assign misalign_o = (r_state == S_DONE) && r_mis && !flush_i;
`endif

    assign busy_o          = (r_state != S_IDLE);
    assign rdata_o         = r_rdata;
    assign bus.bus_addr_o  = {r_addr, {LB{1'b0}}};
    assign bus.bus_we_o    = r_we;
    assign bus.bus_be_o    = r_be;
    assign bus.bus_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit and 64-bit instances.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid64;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  f3;
    logic        rd, wr, flush;

    logic        ready32, rsp32, busy32;
    logic [31:0] rdata32;
    logic        ready64, rsp64, busy64;
    logic [63:0] rdata64;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mis32, mis64;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) b32 ();
    mem_access_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) b64 ();

    mem_access_unit #(.XLEN(32), .ADDR_WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(ready32),
        .addr_i(addr), .wdata_i(wdata[31:0]), .funct3_i(f3),
        .mem_read_i(rd), .mem_write_i(wr), .flush_i(flush),
        .rsp_valid_o(rsp32), .rdata_o(rdata32), .busy_o(busy32),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(mis32),
`endif
        .bus(b32.master)
    );

    mem_access_unit #(.XLEN(64), .ADDR_WIDTH(32)) u64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid64), .req_ready_o(ready64),
        .addr_i(addr), .wdata_i(wdata), .funct3_i(f3),
        .mem_read_i(rd), .mem_write_i(wr), .flush_i(flush),
        .rsp_valid_o(rsp64), .rdata_o(rdata64), .busy_o(busy64),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(mis64),
`endif
        .bus(b64.master)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ld32(string tag, logic [31:0] a, logic [2:0] fn,
                        logic [31:0] word, logic [3:0] ebe,
                        logic [31:0] erd);
        req_valid = 1'b1; addr = a; f3 = fn; rd = 1'b1; wr = 1'b0;
        #1;
        chk({tag, "_ready"}, ready32, 1);
        step;
        req_valid = 1'b0; rd = 1'b0; b32.bus_gnt_i = 1'b1;
        #1;
        chk({tag, "_req"}, b32.bus_req_o, 1);
        chk({tag, "_addr"}, b32.bus_addr_o, a & 32'hFFFF_FFFC);
        chk({tag, "_be"}, b32.bus_be_o, ebe);
        chk({tag, "_we"}, b32.bus_we_o, 0);
        chk({tag, "_busy1"}, busy32, 1);
        step;
        b32.bus_gnt_i = 1'b0; b32.bus_rvalid_i = 1'b1;
        b32.bus_rdata_i = word;
        #1;
        chk({tag, "_req_wait"}, b32.bus_req_o, 0);
        chk({tag, "_rsp_early"}, rsp32, 0);
        chk({tag, "_busy2"}, busy32, 1);
        step;
        b32.bus_rvalid_i = 1'b0; b32.bus_rdata_i = 32'h0;
        #1;
        chk({tag, "_rsp"}, rsp32, 1);
        chk({tag, "_rdata"}, rdata32, erd);
        chk({tag, "_busy3"}, busy32, 1);
        step;
        #1;
        chk({tag, "_rsp_end"}, rsp32, 0);
        chk({tag, "_ready_end"}, ready32, 1);
        chk({tag, "_hold"}, rdata32, erd);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_valid64 = 1'b0;
        addr = '0; wdata = '0; f3 = '0; rd = 1'b0; wr = 1'b0; flush = 1'b0;
        b32.bus_gnt_i = 1'b0; b32.bus_rvalid_i = 1'b0; b32.bus_rdata_i = '0;
        b64.bus_gnt_i = 1'b0; b64.bus_rvalid_i = 1'b0; b64.bus_rdata_i = '0;
        #12;
        chk("rst_ready", ready32, 1);
        chk("rst_busy", busy32, 0);
        chk("rst_req", b32.bus_req_o, 0);
        chk("rst_rsp", rsp32, 0);
        chk("rst_rdata", rdata32, 0);
        chk("rst_be", b32.bus_be_o, 0);
        step;
        rst_n = 1'b1;

        ld32("lw", 32'h100, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        ld32("lb", 32'h103, 3'b000, 32'h80123456, 4'b1000, 32'hFFFFFF80);
        ld32("lbu", 32'h103, 3'b100, 32'h80123456, 4'b1000, 32'h00000080);
        ld32("lh", 32'h102, 3'b001, 32'h9ABC1234, 4'b1100, 32'hFFFF9ABC);

        // SH with grant delayed four cycles
        req_valid = 1'b1; addr = 32'h202; f3 = 3'b001; wr = 1'b1;
        wdata = 64'h0000ABCD;
        step;
        req_valid = 1'b0; wr = 1'b0; wdata = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("sh_req", b32.bus_req_o, 1);
            chk("sh_addr", b32.bus_addr_o, 32'h200);
            chk("sh_be", b32.bus_be_o, 4'b1100);
            chk("sh_wdata", b32.bus_wdata_o, 32'hABCDABCD);
            chk("sh_we", b32.bus_we_o, 1);
            step;
        end
        b32.bus_gnt_i = 1'b1;
        #1;
        chk("sh_req_gnt", b32.bus_req_o, 1);
        step;
        b32.bus_gnt_i = 1'b0;
        #1;
        chk("sh_rsp", rsp32, 1);
        chk("sh_rdata", rdata32, 0);
        step;
        #1;
        chk("sh_ready", ready32, 1);
        chk("sh_rsp_end", rsp32, 0);

        // SB lane replication with immediate grant
        req_valid = 1'b1; addr = 32'h1; f3 = 3'b000; wr = 1'b1;
        wdata = 64'h5A;
        step;
        req_valid = 1'b0; wr = 1'b0; b32.bus_gnt_i = 1'b1;
        #1;
        chk("sb_be", b32.bus_be_o, 4'b0010);
        chk("sb_wdata", b32.bus_wdata_o, 32'h5A5A5A5A);
        step;
        b32.bus_gnt_i = 1'b0;
        #1;
        chk("sb_rsp", rsp32, 1);
        step;

        // Load flushed while waiting for its response
        req_valid = 1'b1; addr = 32'h300; f3 = 3'b010; rd = 1'b1;
        step;
        req_valid = 1'b0; rd = 1'b0; b32.bus_gnt_i = 1'b1;
        step;
        b32.bus_gnt_i = 1'b0; flush = 1'b1;
        #1;
        chk("fl_busy1", busy32, 1);
        chk("fl_rsp1", rsp32, 0);
        step;
        flush = 1'b0;
        #1;
        chk("fl_busy2", busy32, 1);
        chk("fl_ready2", ready32, 0);
        step;
        b32.bus_rvalid_i = 1'b1; b32.bus_rdata_i = 32'h55555555;
        #1;
        chk("fl_busy3", busy32, 1);
        chk("fl_rsp3", rsp32, 0);
        step;
        b32.bus_rvalid_i = 1'b0; b32.bus_rdata_i = '0;
        #1;
        chk("fl_rsp4", rsp32, 0);
        chk("fl_ready4", ready32, 1);
        chk("fl_rdata", rdata32, 0);
        ld32("after_fl", 32'h104, 3'b010, 32'h11223344, 4'b1111,
             32'h11223344);

        // Non-memory op: one-cycle bubble returning zero
        req_valid = 1'b1; addr = 32'h10; rd = 1'b0; wr = 1'b0;
        step;
        req_valid = 1'b0;
        #1;
        chk("nop_rsp", rsp32, 1);
        chk("nop_rdata", rdata32, 0);
        chk("nop_req", b32.bus_req_o, 0);
        step;
        #1;
        chk("nop_ready", ready32, 1);

        // Asynchronous reset in the middle of REQ
        req_valid = 1'b1; addr = 32'h400; f3 = 3'b010; rd = 1'b1;
        step;
        req_valid = 1'b0; rd = 1'b0;
        #1;
        chk("ar_req_pre", b32.bus_req_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_req", b32.bus_req_o, 0);
        chk("ar_ready", ready32, 1);
        chk("ar_busy", busy32, 0);
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ar_no_rsp", rsp32, 0);
            step;
        end

        // 64-bit instance: LD and an upper-word LW
        req_valid64 = 1'b1; addr = 32'h8; f3 = 3'b011; rd = 1'b1;
        step;
        req_valid64 = 1'b0; rd = 1'b0; b64.bus_gnt_i = 1'b1;
        #1;
        chk("ld64_be", b64.bus_be_o, 8'hFF);
        chk("ld64_addr", b64.bus_addr_o, 32'h8);
        step;
        b64.bus_gnt_i = 1'b0; b64.bus_rvalid_i = 1'b1;
        b64.bus_rdata_i = 64'h0123456789ABCDEF;
        step;
        b64.bus_rvalid_i = 1'b0;
        #1;
        chk("ld64_rsp", rsp64, 1);
        chk("ld64_rdata", rdata64, 64'h0123456789ABCDEF);
        step;

        req_valid64 = 1'b1; addr = 32'hC; f3 = 3'b010; rd = 1'b1;
        step;
        req_valid64 = 1'b0; rd = 1'b0; b64.bus_gnt_i = 1'b1;
        #1;
        chk("lw64_be", b64.bus_be_o, 8'hF0);
        chk("lw64_addr", b64.bus_addr_o, 32'h8);
        step;
        b64.bus_gnt_i = 1'b0; b64.bus_rvalid_i = 1'b1;
        b64.bus_rdata_i = 64'h89ABCDEF01234567;
        step;
        b64.bus_rvalid_i = 1'b0;
        #1;
        chk("lw64_rsp", rsp64, 1);
        chk("lw64_rdata", rdata64, 64'hFFFFFFFF89ABCDEF);
        step;

`ifdef MEM_MISALIGN_TRAP_EN
        req_valid = 1'b1; addr = 32'h102; f3 = 3'b010; rd = 1'b1;
        step;
        req_valid = 1'b0; rd = 1'b0;
        #1;
        chk("mis_req", b32.bus_req_o, 0);
        chk("mis_rsp", rsp32, 1);
        chk("mis_flag", mis32, 1);
        chk("mis_rdata", rdata32, 0);
        step;
        #1;
        chk("mis_clear", mis32, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit replacing the single-cycle data-memory access in the MEM stage.
- Accepts one memory operation at a time from the EX/MEM boundary over a valid/ready handshake.
- Drives an external data-memory bus with request/grant and response-valid handshakes, and generates byte enables and store-data lane replication.
- Sign- or zero-extends load data. Holds busy_o so the pipeline stalls while a variable-latency access is in flight.

Parameters:
- XLEN, 32, data and bus width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- NB, XLEN/8 (derived localparam, not overridable), byte lanes per bus word.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  EX/MEM presents an operation.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- addr_i  in  ADDR_WIDTH  byte address (ALU result).
- wdata_i  in  XLEN  store data (rs2).
- funct3_i  in  3  [1:0] size log2 (0=B,1=H,2=W,3=D); [2] unsigned load.
- mem_read_i  in  1  load.
- mem_write_i  in  1  store; mem_read_i and mem_write_i both high = store.
- flush_i  in  1  kill current operation.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rdata_o  out  XLEN  extended load data; 0 for stores and non-memory ops.
- busy_o  out  1  stall request; high whenever the state is not IDLE.
- bus_req_o  out  1  memory request.
- bus_we_o  out  1  1=write.
- bus_addr_o  out  ADDR_WIDTH  word-aligned address (low log2(NB) bits 0).
- bus_be_o  out  NB  byte enables.
- bus_wdata_o  out  XLEN  lane-replicated store data.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  XLEN  read data word.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - All outputs 0 except req_ready_o=1.
  - Internal request registers cleared; flushed flag cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Handshake when req_valid_i && req_ready_o.
  - Memory op: latch addr, size, sign, we, be, wdata; go to REQ.
  - Neither read nor write: go to DONE with rdata 0 (one-cycle bubble, keeps ordering).
- REQ:
  - bus_req_o=1; bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o held stable until bus_gnt_i.
  - On grant: store goes to DONE; load goes to WAIT.
  - Grant with flush_i: store completes silently to IDLE; load goes to WAIT with flushed flag set.
  - flush_i without grant: drop request, go to IDLE, no rsp.
- WAIT:
  - bus_req_o=0.
  - On bus_rvalid_i: select the lane at offset, extend, register into rdata_o.
  - Go to DONE, or to IDLE if flushed (or flush_i this cycle); flushed data is discarded.
  - A flush never abandons an outstanding read response.
- DONE:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - flush_i in DONE suppresses rsp_valid_o.
- Byte enables and store data:
  - off = addr[log2(NB)-1:0], aligned down to the size.
  - be = ((1<<(1<<size))-1) << off.
  - wdata replicated across lanes by size.
  - Size 3 with XLEN=32 is treated as size 2.
- Load data:
  - Byte/half/word taken from bus_rdata_i at off.
  - Sign-extended if funct3_i[2]=0, else zero-extended, to XLEN.
- Latency: minimum load latency is acceptance edge to rsp_valid_o = 3 cycles (gnt in first REQ cycle, rvalid next cycle). Minimum store latency is 2 cycles.
- Bus response ordering: bus_rvalid_i outside WAIT is ignored. bus_gnt_i outside REQ is ignored.
- rdata_o holds its value until the next completion.

Optional Feature:
- MEM_MISALIGN_TRAP_EN
- Defined:
  - An access with off not a multiple of its size (or size 3 with XLEN=32) is not issued; the unit goes IDLE→DONE.
  - In DONE, rsp_valid_o=1, rdata_o=0, and extra output misalign_o=1 for that cycle.
  - misalign_o resets to 0.
- Undefined:
  - misalign_o port absent.
  - Low address bits are silently aligned down to the size and the access is issued.

Test Plan:
- LW, addr 0x100, gnt same cycle, rvalid next with 0xDEADBEEF → bus_be_o=4'b1111, bus_addr_o=0x100; rsp_valid_o 3 cycles after accept with rdata_o=0xDEADBEEF; busy_o high throughout.
- LB addr 0x103, bus_rdata 0x80123456 → be=4'b1000, rdata_o=0xFFFFFF80. LBU same stimulus → 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD, gnt delayed 4 cycles → be=4'b1100, bus_wdata_o=0xABCDABCD; request stable for all 4 stall cycles; rsp_valid_o 1 cycle after grant.
- Load granted, flush_i pulsed in WAIT, rvalid 2 cycles later → no rsp_valid_o; unit returns to IDLE only after rvalid; next request accepted normally.
- rst_n asserted mid-REQ (async, between edges) → bus_req_o=0 and req_ready_o=1 immediately; no rsp_valid_o after release.
- XLEN=64 LD addr 0x8, rdata 0x0123456789ABCDEF → be=8'hFF, rdata_o unchanged. With MEM_MISALIGN_TRAP_EN, LW addr 0x102 → no bus_req_o; rsp_valid_o and misalign_o high in the same cycle.
